// File: rtl/fm_pingpong_pkg.sv
// ---------------------------------------------------------------------------
// fm_pingpong_pkg
// Shared types and helpers for the ping/pong feature-map RAM controller.
//   rd_state_t : read-side FSM states.
//   half_bit   : index of the address bit that selects the ping or pong half.
// ---------------------------------------------------------------------------
package fm_pingpong_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_READ  = 2'd1,
    R_DRAIN = 2'd2
  } rd_state_t;

  // The half-select is the address MSB; everything below it is the beat index.
  function automatic int half_bit(input int addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/fm_frame_counter.sv
// ---------------------------------------------------------------------------
// fm_frame_counter
// Beat counter that wraps to zero after FRAME_LEN-1.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_inc     : advance by one beat (wraps at the last beat)
//   i_clear   : force the count back to zero (has priority over i_inc)
//   o_cnt     : current beat index
//   o_last    : o_cnt is the final beat of the frame
// ---------------------------------------------------------------------------
module fm_frame_counter #(
  parameter int FRAME_LEN = 512,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == LAST_VAL);

  // Beat counter: clear wins, otherwise step and wrap on the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_inc) begin
      r_cnt <= o_last ? {CNT_W{1'b0}} : (r_cnt + CNT_W'(1));
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/fm_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// fm_pingpong_ctrl
// Ping/pong controller for a banked dual-port feature-map RAM. The producer
// writes one frame into one address half on port A while the consumer reads
// the previously completed frame from the other half on port B.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_valid/wr_ready : producer beat handshake (one beat = all SIZE banks)
//   wr_frame_done     : pulse the cycle after a frame's last beat is taken
//   rd_req            : consumer asks for the next frame (sampled when idle)
//   rd_valid/rd_last  : RAM read data valid / final beat of the frame
//   rd_busy           : read FSM not idle
//   ena/wea/addra     : port A bank enables, write enables, address
//   enb/web/addrb     : port B bank enables, write enables (zero), address
//   buf_full          : per-half full flags
// Optional build macro FM_PINGPONG_PERF_EN adds saturating counters
//   wr_stall_cnt (producer stalled) and rd_idle_cnt (consumer starved).
// ---------------------------------------------------------------------------
module fm_pingpong_ctrl
  import fm_pingpong_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int ADDRESS   = 10,
  parameter int FRAME_LEN = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic               wr_frame_done,
  input  logic               rd_req,
  output logic               rd_valid,
  output logic               rd_last,
  output logic               rd_busy,
  output logic [SIZE-1:0]    ena,
  output logic [SIZE-1:0]    wea,
  output logic [ADDRESS-1:0] addra,
  output logic [SIZE-1:0]    enb,
  output logic [SIZE-1:0]    web,
  output logic [ADDRESS-1:0] addrb,
`ifdef FM_PINGPONG_PERF_EN
  output logic [31:0]        wr_stall_cnt,
  output logic [31:0]        rd_idle_cnt,
`endif
  output logic [1:0]         buf_full
);

  localparam int HB = half_bit(ADDRESS);
  localparam int CW = HB;

  if ((FRAME_LEN < 1) || (FRAME_LEN > (1 << HB))) begin : g_bad_frame_len
    $error("fm_pingpong_ctrl: FRAME_LEN must lie in 1..2**(ADDRESS-1)");
  end

  rd_state_t   r_state;
  logic        r_wr_half;
  logic        r_rd_half;
  logic [1:0]  r_buf_full;
  logic        r_wr_frame_done;
  logic        r_rd_valid;
  logic        r_rd_last;

  logic          w_wr_ready;
  logic          w_wr_fire;
  logic          w_wr_last;
  logic          w_wr_set;
  logic          w_rd_reading;
  logic          w_rd_last;
  logic          w_rd_clr;
  logic [CW-1:0] w_wr_cnt;
  logic [CW-1:0] w_rd_cnt;
  logic [1:0]    w_set_mask;
  logic [1:0]    w_clr_mask;

  assign w_wr_ready   = ~r_buf_full[r_wr_half];
  assign w_wr_fire    = wr_valid & w_wr_ready;
  assign w_wr_set     = w_wr_fire & w_wr_last;
  assign w_rd_reading = (r_state == R_READ);
  assign w_rd_clr     = (r_state == R_DRAIN);

  // Set and clear always target opposite halves, so both masks apply together.
  assign w_set_mask = w_wr_set ? (2'b01 << r_wr_half) : 2'b00;
  assign w_clr_mask = w_rd_clr ? (2'b01 << r_rd_half) : 2'b00;

  fm_frame_counter #(.FRAME_LEN(FRAME_LEN), .CNT_W(CW)) u_wr_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_wr_fire),
    .i_clear (1'b0),
    .o_cnt   (w_wr_cnt),
    .o_last  (w_wr_last)
  );

  // Holding the read count at zero while idle guarantees every frame starts at beat 0.
  fm_frame_counter #(.FRAME_LEN(FRAME_LEN), .CNT_W(CW)) u_rd_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_rd_reading),
    .i_clear (r_state == R_IDLE),
    .o_cnt   (w_rd_cnt),
    .o_last  (w_rd_last)
  );

  // Write-side state: half pointer, full flags and frame-done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_half       <= 1'b0;
      r_buf_full      <= 2'b00;
      r_wr_frame_done <= 1'b0;
    end else begin
      r_wr_half       <= r_wr_half ^ w_wr_set;
      r_buf_full      <= (r_buf_full & ~w_clr_mask) | w_set_mask;
      r_wr_frame_done <= w_wr_set;
    end
  end

  // Read FSM; rd_valid/rd_last are the port-B enable and last-beat flag
  // delayed by one cycle to line up with the RAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= R_IDLE;
      r_rd_half  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_reading;
      r_rd_last  <= w_rd_reading & w_rd_last;
      case (r_state)
        R_IDLE: begin
          if (rd_req && r_buf_full[r_rd_half]) begin
            r_state <= R_READ;
          end
        end
        R_READ: begin
          if (w_rd_last) begin
            r_state <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          r_state   <= R_IDLE;
          r_rd_half <= ~r_rd_half;
        end
        default: begin
          r_state <= R_IDLE;
        end
      endcase
    end
  end

`ifdef FM_PINGPONG_PERF_EN
  logic [31:0] r_wr_stall_cnt;
  logic [31:0] r_rd_idle_cnt;

  // Saturating stall/starvation counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_stall_cnt <= 32'd0;
      r_rd_idle_cnt  <= 32'd0;
    end else begin
      if (wr_valid && !w_wr_ready && (r_wr_stall_cnt != 32'hFFFF_FFFF)) begin
        r_wr_stall_cnt <= r_wr_stall_cnt + 32'd1;
      end
      if ((r_state == R_IDLE) && rd_req && !r_buf_full[r_rd_half] &&
          (r_rd_idle_cnt != 32'hFFFF_FFFF)) begin
        r_rd_idle_cnt <= r_rd_idle_cnt + 32'd1;
      end
    end
  end

  assign wr_stall_cnt = r_wr_stall_cnt;
  assign rd_idle_cnt  = r_rd_idle_cnt;
`endif

  assign wr_ready      = w_wr_ready;
  assign wr_frame_done = r_wr_frame_done;
  assign rd_valid      = r_rd_valid;
  assign rd_last       = r_rd_last;
  assign rd_busy       = (r_state != R_IDLE);
  assign ena           = {SIZE{w_wr_fire}};
  assign wea           = {SIZE{w_wr_fire}};
  assign addra         = {r_wr_half, w_wr_cnt};
  assign enb           = {SIZE{w_rd_reading}};
  assign web           = {SIZE{1'b0}};
  assign addrb         = {r_rd_half, w_rd_cnt};
  assign buf_full      = r_buf_full;

endmodule

// File: tb/tb_fm_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fm_pingpong_ctrl
// Random producer/consumer traffic against a frame-level reference model.
// Written beats are queued in order; a RAM model returns data on port B and a
// monitor pops the queue on every rd_valid. Expected control behaviour is
// derived from counts of frames written and drained.
// ---------------------------------------------------------------------------
module tb_fm_pingpong_ctrl;

  localparam int SIZE = 32;
  localparam int ADDRESS = 10;
  localparam int FL = 512;
  localparam int HALF = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic rd_req = 1'b0;
  logic wr_ready, wr_frame_done, rd_valid, rd_last, rd_busy;
  logic [SIZE-1:0] ena, wea, enb, web;
  logic [ADDRESS-1:0] addra, addrb;
  logic [1:0] buf_full;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [31:0] ram [0:(1<<ADDRESS)-1];

  // FRAME_LEN = 1 instance
  logic s_wr_valid = 1'b0;
  logic s_rd_req = 1'b0;
  logic s_wr_ready, s_wr_frame_done, s_rd_valid, s_rd_last, s_rd_busy;
  logic [3:0] s_ena, s_wea, s_enb, s_web;
  logic [1:0] s_addra, s_addrb, s_buf_full;

`ifdef FM_PINGPONG_PERF_EN
  logic [31:0] wr_stall_cnt, rd_idle_cnt, s_wr_stall_cnt, s_rd_idle_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fm_pingpong_ctrl #(.SIZE(SIZE), .ADDRESS(ADDRESS), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_frame_done(wr_frame_done), .rd_req(rd_req), .rd_valid(rd_valid),
    .rd_last(rd_last), .rd_busy(rd_busy), .ena(ena), .wea(wea), .addra(addra),
    .enb(enb), .web(web), .addrb(addrb),
`ifdef FM_PINGPONG_PERF_EN
    .wr_stall_cnt(wr_stall_cnt), .rd_idle_cnt(rd_idle_cnt),
`endif
    .buf_full(buf_full)
  );

  fm_pingpong_ctrl #(.SIZE(4), .ADDRESS(2), .FRAME_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
    .wr_frame_done(s_wr_frame_done), .rd_req(s_rd_req), .rd_valid(s_rd_valid),
    .rd_last(s_rd_last), .rd_busy(s_rd_busy), .ena(s_ena), .wea(s_wea), .addra(s_addra),
    .enb(s_enb), .web(s_web), .addrb(s_addrb),
`ifdef FM_PINGPONG_PERF_EN
    .wr_stall_cnt(s_wr_stall_cnt), .rd_idle_cnt(s_rd_idle_cnt),
`endif
    .buf_full(s_buf_full)
  );

  // RAM array behind the controller: one-cycle read latency on port B.
  always @(posedge clk) begin
    if (ena[0] && wea[0]) ram[addra] <= wdata;
    if (enb[0]) rdata <= ram[addrb];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int fw, fd, n, m;           // frames written/drained, beats written/read
  bit exp_enb, exp_drain, exp_valid, exp_last, done_pend, mon_en;
  logic [31:0] wq[$];
  longint exp_stall, exp_idle;

  int fw0, fd0, set_h, clr_h;
  bit rdy_e, fire, nxt_enb, nxt_drain, set_ev, clr_ev, v_n, l_n;
  logic [1:0] bf_e;

  task automatic model_reset();
    fw = 0; fd = 0; n = 0; m = 0;
    exp_enb = 0; exp_drain = 0; exp_valid = 0; exp_last = 0; done_pend = 0;
    wq.delete();
    exp_stall = 0; exp_idle = 0;
  endtask

  // Monitor: compare every output against the frame-count model each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      fw0 = fw; fd0 = fd;
      bf_e = 2'b00;
      for (int k = fd0; k < fw0; k++) bf_e[k % 2] = 1'b1;
      check("buf_full", buf_full, bf_e);
      rdy_e = (fw0 - fd0) < 2;
      check("wr_ready", wr_ready, rdy_e);
      fire = wr_valid && rdy_e;
      check("ena", ena, {SIZE{fire}});
      check("wea", wea, {SIZE{fire}});
      check("web", web, 0);
      check("wr_frame_done", wr_frame_done, done_pend);
`ifdef FM_PINGPONG_PERF_EN
      check("wr_stall_cnt", wr_stall_cnt, exp_stall);
      check("rd_idle_cnt", rd_idle_cnt, exp_idle);
      if (wr_valid && !rdy_e) exp_stall++;
      if (!exp_enb && !exp_drain && rd_req && !(fw0 > fd0)) exp_idle++;
`endif
      done_pend = 0; set_ev = 0; clr_ev = 0;
      if (fire) begin
        check("addra", addra, ((n / FL) % 2) * HALF + n % FL);
        wq.push_back(wdata);
        n++;
        if (n % FL == 0) begin
          fw++; done_pend = 1; set_ev = 1; set_h = (fw - 1) % 2;
        end
      end
      check("enb", enb, {SIZE{exp_enb}});
      check("rd_busy", rd_busy, exp_enb || exp_drain);
      check("rd_valid", rd_valid, exp_valid);
      check("rd_last", rd_last, exp_last);
      if (rd_valid) begin
        if (wq.size() == 0) check("rd_underflow", 1, 0);
        else check("rd_data", rdata, wq.pop_front());
      end
      nxt_drain = 0;
      if (exp_enb) begin
        check("addrb", addrb, ((m / FL) % 2) * HALF + m % FL);
        m++;
        nxt_enb = (m % FL != 0);
        nxt_drain = (m % FL == 0);
      end else if (exp_drain) begin
        nxt_enb = 0;
      end else begin
        nxt_enb = rd_req && (fw0 > fd0);
      end
      v_n = exp_enb;
      l_n = exp_enb && (m % FL == 0);
      if (exp_last) begin
        clr_ev = 1; clr_h = fd % 2; fd++;
      end
      if (set_ev && clr_ev) check("set_clr_same_half", set_h != clr_h, 1);
      exp_enb = nxt_enb; exp_drain = nxt_drain; exp_valid = v_n; exp_last = l_n;
    end
  end

  task automatic check_rst(input string t);
    check({t, "_wr_ready"}, wr_ready, 1);
    check({t, "_ena"}, ena, 0);
    check({t, "_wea"}, wea, 0);
    check({t, "_enb"}, enb, 0);
    check({t, "_addra"}, addra, 0);
    check({t, "_addrb"}, addrb, 0);
    check({t, "_rd_valid"}, rd_valid, 0);
    check({t, "_rd_last"}, rd_last, 0);
    check({t, "_rd_busy"}, rd_busy, 0);
    check({t, "_frame_done"}, wr_frame_done, 0);
    check({t, "_buf_full"}, buf_full, 0);
  endtask

  // Finish any partial frame, then read everything out.
  task automatic drain(input string t);
    int cyc;
    cyc = 0;
    rd_req = 1'b1;
    wr_valid = 1'b1;
    while (n % FL != 0 && cyc < 5000) begin
      wdata = $urandom; @(posedge clk); #1; cyc++;
    end
    wr_valid = 1'b0;
    while (!(fw == fd && !exp_enb && !exp_drain) && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
    end
    check({t, "_timeout"}, cyc < 5000, 1);
    check({t, "_queue_empty"}, wq.size(), 0);
  endtask

  initial begin
    int cyc;
    mon_en = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_rst("reset");
    rst = 1'b0;
    mon_en = 1;

    // Fill both halves with no reader, then stall for a while.
    for (int i = 0; i < 2 * FL + 20; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1; wdata = $urandom;
    end
    check("both_full", buf_full, 2'b11);

    // Concurrent random traffic.
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk); #1;
      wr_valid = ($urandom_range(0, 9) < 8);
      rd_req = ($urandom_range(0, 9) < 9);
      wdata = $urandom;
    end
    drain("drain1");

    // Reader waiting with nothing to read, then one frame arrives.
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < FL; i++) begin
      wr_valid = 1'b1; wdata = $urandom; @(posedge clk); #1;
    end
    wr_valid = 1'b0;

    // Asynchronous reset in the middle of a read at rd_cnt = 100.
    cyc = 0;
    while (!(enb[0] && addrb[8:0] == 9'd100) && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    check("mid_read_reached", cyc < 2000, 1);
    #1 rst = 1'b1; mon_en = 0;
    #1 check_rst("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("buf_full_after_rst", buf_full, 2'b00);
    model_reset();
    mon_en = 1;

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      wr_valid = ($urandom_range(0, 3) != 0);
      rd_req = ($urandom_range(0, 3) != 0);
      wdata = $urandom;
    end
    drain("drain2");

    // FRAME_LEN = 1: single-beat frames, rd_valid and rd_last together.
    @(posedge clk); #1 s_wr_valid = 1'b1;
    @(posedge clk); #1 s_wr_valid = 1'b0;
    check("fl1_buf_full", s_buf_full, 2'b01);
    check("fl1_frame_done", s_wr_frame_done, 1);
    s_rd_req = 1'b1;
    cyc = 0;
    while (!s_rd_valid && cyc < 10) begin
      @(negedge clk); cyc++;
    end
    check("fl1_rd_seen", cyc < 10, 1);
    check("fl1_rd_last", s_rd_last, 1);
    s_rd_req = 1'b0;
    @(negedge clk);
    check("fl1_one_beat", s_rd_valid, 0);
    check("fl1_buf_empty", s_buf_full, 2'b00);

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fm_pingpong_ctrl.md
Name: fm_pingpong_ctrl

Overview:
- Controller for the banked dual-port feature-map RAM array of a conv layer: SIZE banks, each 2**ADDRESS x WIDTH.
- Port A is the producer's write port. Port B is the consumer's read port.
- The address space is split into two halves (ping/pong) selected by the address MSB, so the next conv layer reads frame N while the current layer writes frame N+1.
- All banks share one address per port. The controller drives the enables, write-enables and addresses; data passes straight through to the RAM.

Parameters:
- SIZE, 32, number of banks (channels per beat).
- ADDRESS, 10, RAM address width. The half-select is bit ADDRESS-1.
- FRAME_LEN, 512, beats per frame. Legal range 1..2**(ADDRESS-1). Elaboration error if outside.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  producer has a beat (all SIZE channels).
- wr_ready  out  1  beat accepted this cycle when wr_valid && wr_ready.
- wr_frame_done  out  1  one-cycle pulse when the last beat of a frame is accepted.
- rd_req  in  1  level: consumer wants the next frame; sampled in R_IDLE.
- rd_valid  out  1  RAM doutb valid this cycle (one cycle after the address is issued).
- rd_last  out  1  qualifies the final rd_valid beat of a frame.
- rd_busy  out  1  read FSM not idle.
- ena  out  SIZE  port A bank enables; all bits equal to the accepted-beat strobe.
- wea  out  SIZE  port A write enables; equal to ena.
- addra  out  ADDRESS  port A address = {wr_half, wr_cnt}.
- enb  out  SIZE  port B bank enables; all bits set during R_READ.
- web  out  SIZE  tied to 0.
- addrb  out  ADDRESS  port B address = {rd_half, rd_cnt}.
- buf_full  out  2  per-half full flags, for status.

Behaviour:
- Reset values:
  - wr_half=0, rd_half=0, wr_cnt=0, rd_cnt=0, buf_full=2'b00, read FSM = R_IDLE.
  - All outputs 0, except wr_ready=1.
- Write side, combinational handshake:
  - wr_ready = !buf_full[wr_half].
  - ena = wea = {SIZE{wr_valid && wr_ready}}; addra = {wr_half, wr_cnt}.
  - On an accepted beat: if wr_cnt==FRAME_LEN-1, then wr_cnt<=0, buf_full[wr_half]<=1, wr_half toggles and wr_frame_done pulses next cycle. Otherwise wr_cnt increments.
  - The write counter never wraps mid-frame.
- Read FSM, states R_IDLE, R_READ, R_DRAIN:
  - R_IDLE -> R_READ when rd_req && buf_full[rd_half]. rd_cnt=0.
  - R_READ: enb all ones, addrb={rd_half, rd_cnt}, rd_cnt increments each cycle. When rd_cnt==FRAME_LEN-1, go to R_DRAIN.
  - R_DRAIN (one cycle): buf_full[rd_half]<=0, rd_half toggles, then go to R_IDLE.
  - rd_valid is enb[0] delayed one cycle. rd_last is (R_READ && rd_cnt==FRAME_LEN-1) delayed one cycle. This matches the RAM's one-cycle read latency.
  - No read backpressure: the consumer must accept every rd_valid beat.
- rd_req deasserted mid-frame has no effect; the frame completes.
- Simultaneous set/clear:
  - A write-side set of buf_full[x] and a read-side clear of buf_full[y] in the same cycle are both applied. x==y is impossible by construction; assert it in the bench.
- Throughput:
  - A full half is writable again on the cycle after R_DRAIN.
  - Steady state: write one beat/cycle, read one beat/cycle, with a 2-cycle inter-frame bubble on the read side (R_DRAIN + R_IDLE).
- Both halves full: wr_ready=0 until a read drain completes.
- FRAME_LEN=1: R_READ lasts one cycle; rd_valid and rd_last assert together.
- Reset mid-operation: all state returns to reset values immediately (async). RAM contents are irrelevant because the full flags clear.

Optional Feature:
- Macro FM_PINGPONG_PERF_EN.
- When defined, adds two outputs:
  - wr_stall_cnt (32): increments each cycle wr_valid && !wr_ready.
  - rd_idle_cnt (32): increments each cycle in R_IDLE with rd_req && !buf_full[rd_half].
- Both counters saturate at all-ones and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package fm_pingpong_pkg holds:
  - rd_state_t enum {R_IDLE, R_READ, R_DRAIN}.
  - localparam function for the half-select bit index.
- One sub-module, fm_frame_counter: parameterised wrap-at-FRAME_LEN counter with inc, clear and last outputs. Instantiated twice, once for wr_cnt and once for rd_cnt.

Test Plan:
- Reset then stream 512 write beats with wr_valid=1 -> addra 0..511, buf_full=01, wr_frame_done one pulse, next beat writes addra=512.
- Fill both halves (1024 beats) -> wr_ready=0 from cycle 1025; wr_stall_cnt counts stall cycles when FM_PINGPONG_PERF_EN is defined.
- rd_req=1 after the first frame -> addrb 0..511 on consecutive cycles, rd_valid 512 cycles starting one cycle later, rd_last on beat 512, buf_full[0] clears after R_DRAIN.
- Concurrent write of frame 2 and read of frame 1 -> no wr_ready drop, data read equals data written (compare against a RAM model), halves alternate 0/1/0.
- rd_req with no full half -> enb stays 0 and rd_busy=0 until buf_full sets, then the read starts the cycle after.
- Assert rst while in R_READ at rd_cnt=100 -> all outputs go to reset values the same cycle, and buf_full=00 after release.
